// File: rtl/systolic_mac_array.sv
// systolic_mac_array: output-stationary DIM x DIM systolic array with a per-cell
// ALU (wrap MAC, saturating MAC, max-plus, min-plus). A and B operand vectors
// are skewed internally, accumulate in place, then drain one row per beat over
// a valid/ready handshake.
// Optional build macro SYSTOLIC_MAC_SAT_FLAG_EN adds a sticky sat_flag output
// that reports wrap (mode 00) or clamp (mode 01) events during the job.
//
// state | meaning
// IDLE  | waiting for the first beat of a job
// FEED  | accepting operand beats until in_last
// DRAIN | flushing the skew/cell pipeline for 2*DIM-1 cycles
// READ  | presenting result rows 0..DIM-1
module systolic_mac_array #(
  parameter int DIM   = 4,
  parameter int W     = 4,
  parameter int ACC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [DIM*W-1:0]         a_in,
  input  logic [DIM*W-1:0]         b_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM*ACC_W-1:0]     out_data,
  output logic [$clog2(DIM)-1:0]   out_row,
  output logic                     busy,
  output logic                     done
`ifdef SYSTOLIC_MAC_SAT_FLAG_EN
  ,output logic                    sat_flag
`endif
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(2*DIM);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2*DIM-2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(DIM-1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, READ} state_t;

  if (ACC_W < 2*W) begin : g_bad_acc_w
    $error("systolic_mac_array: ACC_W must be at least 2*W");
  end

  state_t              state;
  logic [CW-1:0]       drain_cnt;
  logic [1:0]          mode_q;
  logic                accept;
  logic                start;
  logic [1:0]          op_mode;
  logic [ACC_W-1:0]    init_val;
  logic [RW-1:0]       next_row;

  assign in_ready = (state == IDLE) || (state == FEED);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign start    = accept & (state == IDLE);
  // The first beat of a job must already use the new mode and start value,
  // because cell (0,0) consumes it on the same edge that initialises the array.
  assign op_mode  = start ? mode : mode_q;
  assign init_val = (op_mode == 2'b11) ? {ACC_W{1'b1}} : {ACC_W{1'b0}};
  assign next_row = out_row + 1'b1;

  // Operands entering the array edge after the per-lane skew.
  logic [DIM*W-1:0] a_edge;
  logic [DIM*W-1:0] b_edge;
  logic [DIM-1:0]   a_edge_v;
  logic [DIM-1:0]   b_edge_v;

  for (genvar i = 0; i < DIM; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_edge[W-1:0] = a_in[W-1:0];
      assign b_edge[W-1:0] = b_in[W-1:0];
      assign a_edge_v[0]   = accept;
      assign b_edge_v[0]   = accept;
    end else begin : g_delay
      logic [W-1:0] a_d [i];
      logic [W-1:0] b_d [i];
      logic [i-1:0] a_v;
      logic [i-1:0] b_v;

      // Delay lane i by i cycles; bubbles travel as valid = 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) begin
            a_d[k] <= '0;
            b_d[k] <= '0;
          end
          a_v <= '0;
          b_v <= '0;
        end else begin
          a_d[0] <= a_in[i*W +: W];
          b_d[0] <= b_in[i*W +: W];
          a_v[0] <= accept;
          b_v[0] <= accept;
          for (int k = 1; k < i; k++) begin
            a_d[k] <= a_d[k-1];
            b_d[k] <= b_d[k-1];
            a_v[k] <= a_v[k-1];
            b_v[k] <= b_v[k-1];
          end
        end
      end

      assign a_edge[i*W +: W] = a_d[i-1];
      assign b_edge[i*W +: W] = b_d[i-1];
      assign a_edge_v[i]      = a_v[i-1];
      assign b_edge_v[i]      = b_v[i-1];
    end
  end

  // Forwarding registers exist only where a neighbour consumes them:
  // A moves right (columns 0..DIM-2), B moves down (rows 0..DIM-2).
  logic [DIM*(DIM-1)*W-1:0] a_fwd;
  logic [DIM*(DIM-1)-1:0]   a_fwd_v;
  logic [(DIM-1)*DIM*W-1:0] b_fwd;
  logic [(DIM-1)*DIM-1:0]   b_fwd_v;
  logic [DIM*DIM*ACC_W-1:0] acc_all;
`ifdef SYSTOLIC_MAC_SAT_FLAG_EN
  logic [DIM*DIM-1:0]       cell_ovf;
`endif

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      localparam int C = i*DIM + j;

      logic [W-1:0]     a_c;
      logic [W-1:0]     b_c;
      logic             a_cv;
      logic             b_cv;
      logic             upd;
      logic [2*W-1:0]   prod;
      logic [W:0]       ab_sum;
      logic [ACC_W:0]   mac_sum;
      logic [ACC_W-1:0] trop;
      logic [ACC_W-1:0] base;
      logic [ACC_W-1:0] nxt;
      logic [ACC_W-1:0] acc_q;

      if (j == 0) begin : g_a_edge
        assign a_c  = a_edge[i*W +: W];
        assign a_cv = a_edge_v[i];
      end else begin : g_a_nbr
        assign a_c  = a_fwd[(i*(DIM-1)+j-1)*W +: W];
        assign a_cv = a_fwd_v[i*(DIM-1)+j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_c  = b_edge[j*W +: W];
        assign b_cv = b_edge_v[j];
      end else begin : g_b_nbr
        assign b_c  = b_fwd[((i-1)*DIM+j)*W +: W];
        assign b_cv = b_fwd_v[(i-1)*DIM+j];
      end

      assign upd     = a_cv & b_cv;
      assign prod    = a_c * b_c;
      assign ab_sum  = a_c + b_c;
      assign trop    = ACC_W'(ab_sum);
      assign mac_sum = {1'b0, base} + (ACC_W+1)'(prod);

      // Cell ALU: starting value is the job's init value on the first beat.
      always_comb begin
        base = start ? init_val : acc_q;
        nxt  = base;
        if (upd) begin
          case (op_mode)
            2'b00:   nxt = mac_sum[ACC_W-1:0];
            2'b01:   nxt = mac_sum[ACC_W] ? {ACC_W{1'b1}} : mac_sum[ACC_W-1:0];
            2'b10:   nxt = (trop > base) ? trop : base;
            default: nxt = (trop < base) ? trop : base;
          endcase
        end
      end

`ifdef SYSTOLIC_MAC_SAT_FLAG_EN
      assign cell_ovf[C] = upd & ~op_mode[1] & mac_sum[ACC_W];
`endif

      // Accumulator: load on job start or on a valid operand pair, hold on bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else if (start || upd) begin
          acc_q <= nxt;
        end
      end

      assign acc_all[C*ACC_W +: ACC_W] = acc_q;

      if (j < DIM-1) begin : g_a_out
        logic [W-1:0] a_q;
        logic         a_qv;
        // Pass A (with its valid) to the right neighbour every cycle.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q  <= '0;
            a_qv <= 1'b0;
          end else begin
            a_q  <= a_c;
            a_qv <= a_cv;
          end
        end
        assign a_fwd[(i*(DIM-1)+j)*W +: W] = a_q;
        assign a_fwd_v[i*(DIM-1)+j]        = a_qv;
      end

      if (i < DIM-1) begin : g_b_out
        logic [W-1:0] b_q;
        logic         b_qv;
        // Pass B (with its valid) to the lower neighbour every cycle.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            b_q  <= '0;
            b_qv <= 1'b0;
          end else begin
            b_q  <= b_c;
            b_qv <= b_cv;
          end
        end
        assign b_fwd[C*W +: W] = b_q;
        assign b_fwd_v[C]      = b_qv;
      end
    end
  end

  // Job sequencing and result row presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      mode_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mode_q    <= mode;
            drain_cnt <= '0;
            state     <= in_last ? DRAIN : FEED;
          end
        end
        FEED: begin
          if (accept && in_last) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= READ;
            out_valid <= 1'b1;
            out_row   <= '0;
            out_data  <= acc_all[0 +: DIM*ACC_W];
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        READ: begin
          if (out_ready) begin
            if (out_row == ROW_LAST) begin
              out_valid <= 1'b0;
              out_row   <= '0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_row  <= next_row;
              out_data <= acc_all[next_row*DIM*ACC_W +: DIM*ACC_W];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_MAC_SAT_FLAG_EN
  // Sticky overflow flag: cleared when a job starts, held through READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (start) begin
      sat_flag <= 1'b0;
    end else if (|cell_ovf) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule
